// File: rtl/bp_predec_queue_if.sv
// Handshake bundle between the fetch response path, the pre-decode queue and the
// branch predictor. The master side drives fetch words and consumes records.
interface bp_predec_queue_if #(
  parameter int RISCV_ARCH = 64,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  i_flush;
  logic                  i_resp_valid;
  logic                  o_resp_ready;
  logic [RISCV_ARCH-1:0] i_resp_addr;
  logic [31:0]           i_resp_data;
  logic                  o_pd_valid;
  logic                  i_pd_ready;
  logic                  o_pd_c_valid;
  logic [RISCV_ARCH-1:0] o_pd_addr;
  logic [31:0]           o_pd_data;
  logic                  o_pd_jmp;
  logic [RISCV_ARCH-1:0] o_pd_pc;
  logic [RISCV_ARCH-1:0] o_pd_npc;
  logic [CW-1:0]         o_count;

  modport master (
    output i_flush, i_resp_valid, i_resp_addr, i_resp_data, i_pd_ready,
    input  o_resp_ready, o_pd_valid, o_pd_c_valid, o_pd_addr, o_pd_data,
           o_pd_jmp, o_pd_pc, o_pd_npc, o_count
  );

  modport slave (
    input  i_flush, i_resp_valid, i_resp_addr, i_resp_data, i_pd_ready,
    output o_resp_ready, o_pd_valid, o_pd_c_valid, o_pd_addr, o_pd_data,
           o_pd_jmp, o_pd_pc, o_pd_npc, o_count
  );
endinterface

// File: rtl/bp_predec_queue.sv
// Pre-decodes fetched instruction words (compressed flag, static jump prediction,
// next pc) and buffers the records in a small FIFO drained by the branch predictor.
module bp_predec_queue #(
  parameter int RISCV_ARCH = 64,
  parameter int DEPTH      = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  bp_predec_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int A  = RISCV_ARCH;

  typedef struct packed {
    logic          c_valid;
    logic          jmp;
    logic [A-1:0]  addr;
    logic [31:0]   data;
    logic [A-1:0]  npc;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        dec;
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  logic [31:0]   d;
  logic [A-1:0]  imm_j;
  logic [A-1:0]  imm_b;
  logic [A-1:0]  imm_cj;
  logic [A-1:0]  imm_cb;

  assign d      = bus.i_resp_data;
  assign imm_j  = {{(A-21){d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
  assign imm_b  = {{(A-13){d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
  assign imm_cj = {{(A-12){d[12]}}, d[12], d[8], d[10:9], d[6], d[7], d[2], d[11], d[5:3], 1'b0};
  assign imm_cb = {{(A-9){d[12]}}, d[12], d[6:5], d[2], d[11:10], d[4:3], 1'b0};

  // Static prediction: unconditional jumps and backward branches are taken.
  always_comb begin
    dec         = '0;
    dec.addr    = bus.i_resp_addr;
    dec.data    = d;
    dec.c_valid = (d[1:0] != 2'b11);
    dec.jmp     = 1'b0;
    dec.npc     = bus.i_resp_addr + (dec.c_valid ? A'(2) : A'(4));
    if (!dec.c_valid) begin
      if (d[6:0] == 7'b1101111) begin
        dec.jmp = 1'b1;
        dec.npc = bus.i_resp_addr + imm_j;
      end else if (d[6:0] == 7'b1100011 && d[31]) begin
        dec.jmp = 1'b1;
        dec.npc = bus.i_resp_addr + imm_b;
      end
    end else if (d[1:0] == 2'b01) begin
      if (d[15:13] == 3'b101) begin
        dec.jmp = 1'b1;
        dec.npc = bus.i_resp_addr + imm_cj;
      end else if (d[15:14] == 2'b11 && d[12]) begin
        dec.jmp = 1'b1;
        dec.npc = bus.i_resp_addr + imm_cb;
      end
    end
  end

  assign bus.o_resp_ready = (count < CW'(DEPTH)) && !bus.i_flush;
  assign bus.o_pd_valid   = (count != '0);
  assign push             = bus.i_resp_valid && bus.o_resp_ready;
  assign pop              = bus.o_pd_valid && bus.i_pd_ready && !bus.i_flush;

  assign head             = mem[rd_ptr];
  assign bus.o_pd_c_valid = head.c_valid;
  assign bus.o_pd_jmp     = head.jmp;
  assign bus.o_pd_addr    = head.addr;
  assign bus.o_pd_pc      = head.addr;
  assign bus.o_pd_data    = head.data;
  assign bus.o_pd_npc     = head.npc;
  assign bus.o_count      = count;

  // Flush only rewinds pointers; stale entries are unreachable once count is zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_bp_predec_queue.sv
// Randomized scoreboard bench for bp_predec_queue: a reference decoder and a queue
// model predict every record, count and handshake the DUT should present.
module tb_bp_predec_queue;
  localparam int A     = 64;
  localparam int DEPTH = 4;

  typedef struct {
    logic        c_valid;
    logic        jmp;
    logic [63:0] addr;
    logic [31:0] data;
    logic [63:0] npc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  bit   model_valid = 1'b0;
  bit   zero_check  = 1'b0;

  bp_predec_queue_if #(.RISCV_ARCH(A), .DEPTH(DEPTH)) bus ();

  bp_predec_queue #(.RISCV_ARCH(A), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference decoder: immediates rebuilt as weighted sums of instruction bit fields.
  function automatic exp_t ref_decode(input logic [63:0] addr, input logic [31:0] d);
    exp_t        e;
    int          imm;
    logic [63:0] off;
    e.addr    = addr;
    e.data    = d;
    e.c_valid = (d[1:0] != 2'b11);
    e.jmp     = 1'b0;
    imm       = e.c_valid ? 2 : 4;
    if (d[6:0] == 7'h6F) begin
      e.jmp = 1'b1;
      imm = int'(d[30:21]) * 2 + int'(d[20]) * 2048 + int'(d[19:12]) * 4096 - (d[31] ? (1 << 20) : 0);
    end else if (d[6:0] == 7'h63 && d[31]) begin
      e.jmp = 1'b1;
      imm = int'(d[11:8]) * 2 + int'(d[30:25]) * 32 + int'(d[7]) * 2048 - 4096;
    end else if (d[1:0] == 2'b01 && d[15:13] == 3'b101) begin
      e.jmp = 1'b1;
      imm = int'(d[5:3]) * 2 + int'(d[11]) * 16 + int'(d[2]) * 32 + int'(d[7]) * 64
          + int'(d[6]) * 128 + int'(d[10:9]) * 256 + int'(d[8]) * 1024 - (d[12] ? 2048 : 0);
    end else if (d[1:0] == 2'b01 && (d[15:13] == 3'b110 || d[15:13] == 3'b111) && d[12]) begin
      e.jmp = 1'b1;
      imm = int'(d[4:3]) * 2 + int'(d[11:10]) * 8 + int'(d[2]) * 32 + int'(d[6:5]) * 64 - 256;
    end
    off   = 64'(signed'(imm));
    e.npc = addr + off;
    return e;
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return {r[31:7], 7'h6F};
      1:       return {r[31:7], 7'h63};
      2:       return {r[31:16], 3'b101, r[12:2], 2'b01};
      3:       return {r[31:16], 2'b11, r[13:2], 2'b01};
      4:       return {r[31:2], 2'b01};
      default: return r;
    endcase
  endfunction

  // Monitor: compare the visible state against the model, then advance the model
  // by whatever handshakes the current inputs will complete at the next edge.
  always @(negedge clk) begin
    bit can_push;
    if (model_valid) begin
      checkOutput("count", 64'(bus.o_count), 64'(sb.size()));
      checkOutput("resp_ready", 64'(bus.o_resp_ready), 64'(sb.size() < DEPTH && !bus.i_flush));
      checkOutput("pd_valid", 64'(bus.o_pd_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        checkOutput("pd_c_valid", 64'(bus.o_pd_c_valid), 64'(sb[0].c_valid));
        checkOutput("pd_jmp", 64'(bus.o_pd_jmp), 64'(sb[0].jmp));
        checkOutput("pd_addr", bus.o_pd_addr, sb[0].addr);
        checkOutput("pd_pc", bus.o_pd_pc, sb[0].addr);
        checkOutput("pd_data", 64'(bus.o_pd_data), 64'(sb[0].data));
        checkOutput("pd_npc", bus.o_pd_npc, sb[0].npc);
      end else if (zero_check) begin
        checkOutput("rst_fields", {bus.o_pd_c_valid, bus.o_pd_jmp, bus.o_pd_addr[61:0]} | bus.o_pd_pc
                    | bus.o_pd_npc | 64'(bus.o_pd_data), 64'h0);
      end
    end
    if (rst) begin
      sb.delete();
      model_valid = 1'b1;
      zero_check  = 1'b1;
    end else if (model_valid) begin
      if (bus.i_flush) begin
        sb.delete();
        zero_check = 1'b0;
      end else begin
        can_push = bus.i_resp_valid && (sb.size() < DEPTH);
        if (bus.i_pd_ready && sb.size() != 0) void'(sb.pop_front());
        if (can_push) begin
          sb.push_back(ref_decode(bus.i_resp_addr, bus.i_resp_data));
          zero_check = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic valid, input logic [63:0] addr, input logic [31:0] data,
                               input logic pd_ready, input logic flush, input logic do_rst);
    bus.i_resp_valid = valid;
    bus.i_resp_addr  = addr;
    bus.i_resp_data  = data;
    bus.i_pd_ready   = pd_ready;
    bus.i_flush      = flush;
    rst              = do_rst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic valid, input logic [63:0] addr, input logic [31:0] data,
                      input logic pd_ready, input logic flush, input logic do_rst);
    applyStimulus(valid, addr, data, pd_ready, flush, do_rst);
    tick();
  endtask

  initial begin
    applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_count", 64'(bus.o_count), 64'd0);
    checkOutput("reset_ready", 64'(bus.o_resp_ready), 64'd1);
    checkOutput("reset_valid", 64'(bus.o_pd_valid), 64'd0);

    step(1'b1, 64'h8000_0000, 32'h0100_006F, 1'b0, 1'b0, 1'b0);
    checkOutput("jal_valid", 64'(bus.o_pd_valid), 64'd1);
    checkOutput("jal_c", 64'(bus.o_pd_c_valid), 64'd0);
    checkOutput("jal_jmp", 64'(bus.o_pd_jmp), 64'd1);
    checkOutput("jal_pc", bus.o_pd_pc, 64'h8000_0000);
    checkOutput("jal_npc", bus.o_pd_npc, 64'h8000_0010);
    checkOutput("jal_count", 64'(bus.o_count), 64'd1);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    step(1'b1, 64'h1000, 32'hFE00_0CE3, 1'b0, 1'b0, 1'b0);
    checkOutput("bback_jmp", 64'(bus.o_pd_jmp), 64'd1);
    checkOutput("bback_npc", bus.o_pd_npc, 64'h0FF8);
    step(1'b1, 64'h1004, 32'h0000_0463, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("bfwd_jmp", 64'(bus.o_pd_jmp), 64'd0);
    checkOutput("bfwd_npc", bus.o_pd_npc, 64'h1008);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    step(1'b1, 64'h2000, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    checkOutput("cnop_c", 64'(bus.o_pd_c_valid), 64'd1);
    checkOutput("cnop_jmp", 64'(bus.o_pd_jmp), 64'd0);
    checkOutput("cnop_npc", bus.o_pd_npc, 64'h2002);
    step(1'b1, 64'h2002, 32'h0000_A001, 1'b1, 1'b0, 1'b0);
    checkOutput("cj_c", 64'(bus.o_pd_c_valid), 64'd1);
    checkOutput("cj_jmp", 64'(bus.o_pd_jmp), 64'd1);
    checkOutput("cj_npc", bus.o_pd_npc, 64'h2002);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) step(1'b1, 64'h3000 + 64'(4 * i), gen_word(), 1'b0, 1'b0, 1'b0);
    checkOutput("full_count", 64'(bus.o_count), 64'd4);
    checkOutput("full_ready", 64'(bus.o_resp_ready), 64'd0);
    step(1'b1, 64'h3100, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    checkOutput("full_nopush", 64'(bus.o_count), 64'd4);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("pop_count", 64'(bus.o_count), 64'd3);
    checkOutput("pop_ready", 64'(bus.o_resp_ready), 64'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 64'h4000 + 64'(4 * i), gen_word(), 1'b1, 1'b0, 1'b0);
    checkOutput("wrap_count", 64'(bus.o_count), 64'd3);

    applyStimulus(1'b1, 64'h5000, 32'h0000_006F, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("flush_ready", 64'(bus.o_resp_ready), 64'd0);
    tick();
    checkOutput("flush_count", 64'(bus.o_count), 64'd0);
    checkOutput("flush_valid", 64'(bus.o_pd_valid), 64'd0);

    step(1'b1, 64'h6000, gen_word(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h6004, gen_word(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h6008, gen_word(), 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("rst_count", 64'(bus.o_count), 64'd0);
    checkOutput("rst_valid", 64'(bus.o_pd_valid), 64'd0);
    checkOutput("rst_npc", bus.o_pd_npc, 64'd0);
    checkOutput("rst_ready", 64'(bus.o_resp_ready), 64'd1);
    tick();

    for (int i = 0; i < 400; i++) begin
      logic [63:0] addr;
      addr = {$urandom, $urandom};
      addr[0] = 1'b0;
      if (i % 50 == 7) addr = 64'hFFFF_FFFF_FFFF_FFFE;
      step($urandom_range(0, 3) != 0, addr, gen_word(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
